// File: rtl/gcd_req_sched.sv
// Round-robin front end that shares one go/done GCD engine among NREQ requesters.
// Zero-operand requests are answered directly and never reach the engine.
module gcd_req_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255,
    parameter int IDW     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    eng_go,
    output logic [WIDTH-1:0]        eng_a,
    output logic [WIDTH-1:0]        eng_b,
    input  logic                    eng_done,
    input  logic [WIDTH-1:0]        eng_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_result,
    output logic                    rsp_err,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] engA_q, engA_d;
    logic [WIDTH-1:0] engB_q, engB_d;
    logic [IDW-1:0]   rspId_q, rspId_d;
    logic [WIDTH-1:0] rspResult_q, rspResult_d;
    logic             rspErr_q, rspErr_d;

    logic             grantValid;
    logic [IDW-1:0]   grantIdx;
    logic [WIDTH-1:0] selA, selB;

    // Scan from the round-robin pointer and grant the first valid requester.
    always_comb begin
        int idx;
        idx        = 0;
        grantValid = 1'b0;
        grantIdx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grantValid && req_valid[idx]) begin
                grantValid = 1'b1;
                grantIdx   = IDW'(idx);
            end
        end
        selA = req_a[int'(grantIdx)*WIDTH +: WIDTH];
        selB = req_b[int'(grantIdx)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            timer_q     <= '0;
            engA_q      <= '0;
            engB_q      <= '0;
            rspId_q     <= '0;
            rspResult_q <= '0;
            rspErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            engA_q      <= engA_d;
            engB_q      <= engB_d;
            rspId_q     <= rspId_d;
            rspResult_q <= rspResult_d;
            rspErr_q    <= rspErr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        engA_d      = engA_q;
        engB_d      = engB_q;
        rspId_d     = rspId_q;
        rspResult_d = rspResult_q;
        rspErr_d    = rspErr_q;
        unique case (state_q)
            IDLE: begin
                if (grantValid) begin
                    rspId_d = grantIdx;
                    ptr_d   = (int'(grantIdx) == NREQ - 1) ? '0 : IDW'(grantIdx + 1'b1);
                    // gcd(x,0) = x, so a zero operand is answered with A|B.
                    if (selA == '0 || selB == '0) begin
                        rspResult_d = selA | selB;
                        rspErr_d    = 1'b0;
                        state_d     = RESP;
                    end else begin
                        engA_d  = selA;
                        engB_d  = selB;
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    rspResult_d = eng_result;
                    rspErr_d    = 1'b0;
                    state_d     = RESP;
                end else if (timer_q == TLAST) begin
                    rspResult_d = '0;
                    rspErr_d    = 1'b1;
                    state_d     = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (rst && state_q == IDLE && grantValid) req_ready[grantIdx] = 1'b1;
        eng_go     = (state_q == LAUNCH);
        rsp_valid  = (state_q == RESP);
        busy       = (state_q != IDLE);
        eng_a      = engA_q;
        eng_b      = engB_q;
        rsp_id     = rspId_q;
        rsp_result = rspResult_q;
        rsp_err    = rspErr_q;
    end

endmodule

// File: tb/tb_gcd_req_sched.sv
// Directed bench for gcd_req_sched: table of single requests plus hand-written
// reset, round-robin and abort sequences; the engine is modelled by the bench.
module tb_gcd_req_sched;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  eng_go;
    logic [WIDTH-1:0]      eng_a;
    logic [WIDTH-1:0]      eng_b;
    logic                  eng_done;
    logic [WIDTH-1:0]      eng_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_err;
    logic                  busy;

    int testsRun = 0;
    int testsFailed = 0;

    // doneDelay < 0 means the engine never answers.
    typedef struct {
        int id;
        int a;
        int b;
        int doneDelay;
        int engResult;
        int expResult;
        bit expErr;
        bit bypass;
        int bpCycles;
    } vec_t;

    vec_t vecs[8];

    gcd_req_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .eng_go(eng_go), .eng_a(eng_a), .eng_b(eng_b),
        .eng_done(eng_done), .eng_result(eng_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int n;
        @(negedge clk);
        req_a[v.id*WIDTH +: WIDTH] = WIDTH'(v.a);
        req_b[v.id*WIDTH +: WIDTH] = WIDTH'(v.b);
        req_valid[v.id] = 1'b1;
        #1;
        n = 0;
        while (req_ready[v.id] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("grantOneHot", 32'(req_ready), 32'(1) << v.id);
        if (n >= 20) begin
            req_valid = '0;
            return;
        end
        @(posedge clk); #1;
        req_valid[v.id] = 1'b0;
        if (v.bypass) begin
            checkOutput("bypassNoGo", 32'(eng_go), 0);
            checkOutput("bypassLatency", 32'(rsp_valid), 1);
        end else begin
            checkOutput("goPulse", 32'(eng_go), 1);
            checkOutput("engA", 32'(eng_a), 32'(v.a));
            checkOutput("engB", 32'(eng_b), 32'(v.b));
            @(posedge clk); #1;
            checkOutput("goSingle", 32'(eng_go), 0);
            if (v.doneDelay < 0) begin
                repeat (TIMEOUT - 1) begin @(posedge clk); #1; end
                checkOutput("noEarlyTimeout", 32'(rsp_valid), 0);
                @(posedge clk); #1;
            end else begin
                repeat (v.doneDelay) begin @(posedge clk); #1; end
                checkOutput("noEarlyRsp", 32'(rsp_valid), 0);
                eng_done   = 1'b1;
                eng_result = WIDTH'(v.engResult);
                @(posedge clk); #1;
                eng_done = 1'b0;
            end
            checkOutput("engAHeld", 32'(eng_a), 32'(v.a));
        end
        checkOutput("rspValid", 32'(rsp_valid), 1);
        checkOutput("rspId", 32'(rsp_id), 32'(v.id));
        checkOutput("rspResult", 32'(rsp_result), 32'(v.expResult));
        checkOutput("rspErr", 32'(rsp_err), 32'(v.expErr));
        checkOutput("busyResp", 32'(busy), 1);
        // Backpressure with other requesters pending and a stray engine done.
        for (int c = 0; c < v.bpCycles; c++) begin
            req_valid  = '1;
            eng_done   = 1'b1;
            eng_result = 8'hAA;
            #1;
            checkOutput("bpReqReady", 32'(req_ready), 0);
            @(posedge clk); #1;
            eng_done = 1'b0;
            checkOutput("bpValid", 32'(rsp_valid), 1);
            checkOutput("bpId", 32'(rsp_id), 32'(v.id));
            checkOutput("bpResult", 32'(rsp_result), 32'(v.expResult));
            checkOutput("bpErr", 32'(rsp_err), 32'(v.expErr));
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checkOutput("rspDrop", 32'(rsp_valid), 0);
        checkOutput("busyIdle", 32'(busy), 0);
        eng_done   = 1'b1;
        eng_result = 8'h55;
        @(posedge clk); #1;
        eng_done = 1'b0;
        checkOutput("lateDoneIdleBusy", 32'(busy), 0);
        checkOutput("lateDoneIdleRsp", 32'(rsp_valid), 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{2,  48, 18, 10,  6,   6, 1'b0, 1'b0, 0};
        vecs[1] = '{1,   0, 35,  0,  0,  35, 1'b0, 1'b1, 0};
        vecs[2] = '{0,   0,  0,  0,  0,   0, 1'b0, 1'b1, 0};
        vecs[3] = '{3, 200,  0,  0,  0, 200, 1'b0, 1'b1, 2};
        vecs[4] = '{3,  21, 14,  0,  7,   7, 1'b0, 1'b0, 0};
        vecs[5] = '{1, 100, 75, 15, 25,  25, 1'b0, 1'b0, 0};
        vecs[6] = '{0,   9,  6, -1,  0,   0, 1'b1, 1'b0, 3};
        vecs[7] = '{2, 255, 17,  3, 17,  17, 1'b0, 1'b0, 5};

        rst        = 1'b0;
        req_valid  = '1;
        req_a      = {8'd7, 8'd7, 8'd7, 8'd7};
        req_b      = {8'd3, 8'd3, 8'd3, 8'd3};
        eng_done   = 1'b0;
        eng_result = '0;
        rsp_ready  = 1'b0;

        // Reset held with every requester valid.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstReqReady", 32'(req_ready), 0);
        checkOutput("rstRspValid", 32'(rsp_valid), 0);
        checkOutput("rstEngGo", 32'(eng_go), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstEngA", 32'(eng_a), 0);
        rst = 1'b1;
        #1;
        checkOutput("rstFirstGrant", 32'(req_ready), 32'h1);
        req_valid = '0;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Abort mid-WAIT: pointer returns to 0 and the late done is ignored.
        @(negedge clk);
        req_a[1*WIDTH +: WIDTH] = 8'd12;
        req_b[1*WIDTH +: WIDTH] = 8'd8;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        checkOutput("abortGo", 32'(eng_go), 1);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("abortInWait", 32'(busy), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checkOutput("abortBusy", 32'(busy), 0);
        checkOutput("abortRspValid", 32'(rsp_valid), 0);
        checkOutput("abortEngA", 32'(eng_a), 0);
        checkOutput("abortEngB", 32'(eng_b), 0);
        checkOutput("abortRspId", 32'(rsp_id), 0);
        checkOutput("abortRspResult", 32'(rsp_result), 0);
        checkOutput("abortRspErr", 32'(rsp_err), 0);
        eng_done   = 1'b1;
        eng_result = 8'd4;
        @(posedge clk); #1;
        eng_done = 1'b0;
        checkOutput("abortLateDone", 32'(busy), 0);

        // Round-robin with all requesters continuously valid.
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = WIDTH'((i + 1) * 6);
            req_b[i*WIDTH +: WIDTH] = WIDTH'((i + 1) * 4);
        end
        req_valid = '1;
        #1;
        for (int k = 0; k < 5; k++) begin
            int expId;
            expId = k % NREQ;
            n = 0;
            while (req_ready == '0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            checkOutput("rrGrant", 32'(req_ready), 32'(1) << expId);
            @(posedge clk); #1;
            checkOutput("rrGo", 32'(eng_go), 1);
            checkOutput("rrEngA", 32'(eng_a), 32'((expId + 1) * 6));
            @(posedge clk); #1;
            eng_done   = 1'b1;
            eng_result = 8'd1;
            @(posedge clk); #1;
            eng_done = 1'b0;
            checkOutput("rrRspValid", 32'(rsp_valid), 1);
            checkOutput("rrRspId", 32'(rsp_id), 32'(expId));
            checkOutput("rrRspResult", 32'(rsp_result), 1);
            rsp_ready = 1'b1;
            checkOutput("rrNoAcceptInHandshake", 32'(req_ready), 0);
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
        req_valid = '0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/gcd_req_sched.md
Name: gcd_req_sched

Overview:
- Round-robin scheduler that shares one GCD engine among NREQ requesters.
- The engine is the controller/datapath pair driven by go/done.
- Accepts one operand pair at a time and launches the engine.
- Waits for done, with a timeout, then returns the result tagged with the requester id.
- Zero-operand requests are answered directly, without using the engine.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- TIMEOUT, 255, max cycles in WAIT before error response (>=1)
- IDW, 2, width of requester id; must satisfy 2^IDW >= NREQ

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- eng_go  out  1  one-cycle engine start pulse
- eng_a  out  WIDTH  operand A to engine
- eng_b  out  WIDTH  operand B to engine
- eng_done  in  1  engine completion pulse
- eng_result  in  WIDTH  engine GCD result, valid with eng_done
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester id of response
- rsp_result  out  WIDTH  GCD result
- rsp_err  out  1  1 = engine timeout, result forced 0
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- Reset (rst=0 at a clock edge):
  - state=IDLE, ptr=0, timer=0.
  - eng_go=0, eng_a=0, eng_b=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0.
  - req_ready=0 while rst=0.
  - Reset in any state aborts the operation. A late eng_done is ignored.
- Arbitration (combinational, IDLE only):
  - grant = first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod NREQ.
  - req_ready[grant]=1, all other bits 0. req_ready is all 0 outside IDLE or if no valid.
- Accept edge (IDLE, req_valid[g]&&req_ready[g]):
  - Capture A, B and id=g.
  - ptr <= (g+1) mod NREQ.
  - If A==0 or B==0: rsp_result <= A|B (gcd(0,0)=0), rsp_err <= 0, next=RESP; engine untouched.
  - Otherwise: eng_a <= A, eng_b <= B, next=LAUNCH.
- LAUNCH: eng_go=1 for exactly this one cycle; timer <= 0; next=WAIT.
- eng_a/eng_b are held stable from the accept edge until RESP exits.
- WAIT, checked in this priority order each cycle:
  1. eng_done=1: rsp_result <= eng_result, rsp_err <= 0, next=RESP.
  2. timer==TIMEOUT-1: rsp_result <= 0, rsp_err <= 1, next=RESP.
  3. Otherwise timer increments.
  - eng_done and timeout in the same cycle: done wins.
- eng_done outside WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result, rsp_err held stable.
  - Holds until rsp_ready=1 at an edge, then next=IDLE and rsp_valid drops.
  - No new request is accepted in the handshake cycle; the earliest next accept is the cycle after.
- Latency, with accept at edge N:
  - Zero-operand: rsp_valid high in cycle N+1.
  - Engine path: eng_go high in cycle N+1, WAIT from N+2. eng_done sampled at edge M gives rsp_valid from cycle M+1.
- Fairness: a requester that holds req_valid is granted within NREQ accepts.
- Requesters must hold req_a/req_b stable while req_valid=1. Dropping req_valid before accept is legal and causes no capture.
- busy=1 in LAUNCH, WAIT, RESP.

Test Plan:
- Reset: hold rst=0 three cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, eng_go=0. Release rst -> requester 0 granted first.
- Single request: req 2 sends A=48, B=18; engine model returns 6 after 10 cycles -> eng_go is a single pulse with eng_a=48, eng_b=18; rsp_valid, rsp_id=2, rsp_result=6, rsp_err=0.
- Round-robin: all four valid continuously, each engine op returns 1 -> grant order 0,1,2,3,0. ptr advances; no requester starved.
- Zero bypass: A=0,B=35 -> rsp_result=35 one cycle after accept, eng_go never asserted. Repeat with A=0,B=0 -> result 0.
- Timeout: TIMEOUT=16, engine never asserts done -> rsp_err=1, rsp_result=0 after 16 WAIT cycles. A late eng_done in RESP/IDLE is ignored. Also check done and timeout in the same cycle -> done wins, err=0.
- Backpressure and reset: rsp_ready=0 for 5 cycles -> rsp fields stable, req_ready all 0. Assert rst mid-WAIT -> IDLE, ptr=0, all outputs at reset values.
